// File: rtl/instr_align_buffer.sv
// Purpose : realigns word-aligned 32-bit fetch words into a halfword stream and issues
//           one RV32C instruction (16- or 32-bit) per handshake together with its PC.
// Latency : a word accepted in cycle t can produce its first instruction in cycle t+1.
// Backpr. : FetchReady_o drops when fewer than 2 halfword slots are free; outputs hold while
//           InstrReady_i is low; Redirect_i blocks both handshakes for the cycle it is high.
// Ports   : clk_i / rst_i (async, active-high)
//           FetchAddr_o, FetchReady_o, FetchValid_i, FetchData_i   - fetch side
//           Redirect_i, RedirectPC_i                               - flush and restart
//           InstrValid_o, InstrReady_i, Instr_o, InstrPC_o,
//           Compressed_o, Illegal_o                                - decode side
// Config  : define RVC_EXPAND_EN to expand the supported 16-bit subset into 32-bit
//           equivalents (unsupported encodings flag Illegal_o). Without it 16-bit
//           encodings are passed through zero-extended.
module instr_align_buffer #(
  parameter int          DEPTH_HW = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] FetchAddr_o,
  output logic        FetchReady_o,
  input  logic        FetchValid_i,
  input  logic [31:0] FetchData_i,
  input  logic        Redirect_i,
  input  logic [31:0] RedirectPC_i,
  output logic        InstrValid_o,
  input  logic        InstrReady_i,
  output logic [31:0] Instr_o,
  output logic [31:0] InstrPC_o,
  output logic        Compressed_o,
  output logic        Illegal_o
);

  localparam int PTR_W = $clog2(DEPTH_HW);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem_q [DEPTH_HW];
  logic [15:0]      mem_d [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      pc_q, pc_d;
  logic             drop_q, drop_d;

  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [15:0]      head_hw, next_hw;
  logic             is_32;
  logic [CNT_W-1:0] free_cnt;
  logic             have_instr;
  logic             fetch_acc, instr_acc;
  logic [1:0]       push_n, pop_n;

  // Halfword 0 of the redirect target is never needed: the drop flag covers it.
  logic unused_redirect_bit0;
  assign unused_redirect_bit0 = RedirectPC_i[0];

`ifdef RVC_EXPAND_EN
  // Returns {illegal, expanded_instr}; expanded_instr is 0 when illegal.
  function automatic logic [32:0] rvc_expand(input logic [15:0] c);
    logic [31:0] ins;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs2p;
    ins  = '0;
    ill  = 1'b0;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b010:  ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rdp, 3'b010, rs2p, 7'b0000011};
          3'b110:  ins = {5'b0, c[5], c[12], rs2p, rdp, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: ins = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'b0010011};
          3'b001, 3'b101:
            ins = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                   c[12], {8{c[12]}}, (c[15] ? 5'd0 : 5'd1), 7'b1101111};
          3'b010: ins = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                if (c[12]) ill = 1'b1;
                else       ins = {7'b0000000, c[6:2], rdp, 3'b101, rdp, 7'b0010011};
              end
              2'b01: begin
                if (c[12]) ill = 1'b1;
                else       ins = {7'b0100000, c[6:2], rdp, 3'b101, rdp, 7'b0010011};
              end
              2'b10: ins = {{7{c[12]}}, c[6:2], rdp, 3'b111, rdp, 7'b0010011};
              default: begin
                if (c[12]) ill = 1'b1;
                else begin
                  case (c[6:5])
                    2'b00:   ins = {7'b0100000, rs2p, rdp, 3'b000, rdp, 7'b0110011};
                    2'b01:   ins = {7'b0000000, rs2p, rdp, 3'b100, rdp, 7'b0110011};
                    2'b10:   ins = {7'b0000000, rs2p, rdp, 3'b110, rdp, 7'b0110011};
                    default: ins = {7'b0000000, rs2p, rdp, 3'b111, rdp, 7'b0110011};
                  endcase
                end
              end
            endcase
          end
          3'b110, 3'b111:
            ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp, {2'b00, c[13]},
                   c[11:10], c[4:3], c[12], 7'b1100011};
          default: ill = 1'b1;
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            if (c[12]) ill = 1'b1;
            else       ins = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
          end
          3'b100: begin
            if (rs2 == 5'd0) begin
              // c.jr / c.jalr; rd==0 is reserved or c.ebreak, neither supported
              if (rd == 5'd0) ill = 1'b1;
              else            ins = {12'b0, rd, 3'b000, (c[12] ? 5'd1 : 5'd0), 7'b1100111};
            end else begin
              // c.mv is add rd,x0,rs2; c.add is add rd,rd,rs2
              ins = {7'b0000000, rs2, (c[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
            end
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) ins = '0;
    return {ill, ins};
  endfunction
`endif

  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
  assign head_hw    = mem_q[rd_ptr_q];
  assign next_hw    = mem_q[rd_ptr_nxt];
  assign is_32      = &head_hw[1:0];
  assign free_cnt   = CNT_W'(DEPTH_HW) - count_q;

  // Ready looks only at the current count, so a full buffer refuses a word
  // even in a cycle where it is also popping.
  assign FetchReady_o = (free_cnt >= CNT_W'(2)) & ~Redirect_i;
  assign have_instr   = is_32 ? (count_q >= CNT_W'(2)) : (count_q != '0);
  assign InstrValid_o = have_instr & ~Redirect_i;
  assign fetch_acc    = FetchValid_i & FetchReady_o;
  assign instr_acc    = InstrValid_o & InstrReady_i;

  assign FetchAddr_o  = fetch_addr_q;
  assign InstrPC_o    = pc_q;

  always_comb begin
    Instr_o      = '0;
    Compressed_o = 1'b0;
    Illegal_o    = 1'b0;
    if (InstrValid_o) begin
      if (is_32) begin
        Instr_o = {next_hw, head_hw};
      end else begin
        Compressed_o = 1'b1;
`ifdef RVC_EXPAND_EN
        {Illegal_o, Instr_o} = rvc_expand(head_hw);
`else
        Instr_o = {16'b0, head_hw};
`endif
      end
    end
  end

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    push_n       = 2'd0;
    pop_n        = 2'd0;
    if (Redirect_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = {RedirectPC_i[31:2], 2'b00};
      pc_d         = {RedirectPC_i[31:1], 1'b0};
      drop_d       = RedirectPC_i[1];
    end else begin
      if (fetch_acc) begin
        if (drop_q) begin
          // target was the upper halfword: skip the lower one once
          mem_d[wr_ptr_q] = FetchData_i[31:16];
          push_n          = 2'd1;
          drop_d          = 1'b0;
        end else begin
          mem_d[wr_ptr_q]   = FetchData_i[15:0];
          mem_d[wr_ptr_nxt] = FetchData_i[31:16];
          push_n            = 2'd2;
        end
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
      if (instr_acc) begin
        pop_n = is_32 ? 2'd2 : 2'd1;
        pc_d  = pc_q + (is_32 ? 32'd4 : 32'd2);
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_HW; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      pc_q         <= {RESET_PC[31:1], 1'b0};
      drop_q       <= RESET_PC[1];
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_instr_align_buffer.sv
module tb_instr_align_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] FetchAddr_o;
  logic        FetchReady_o;
  logic        FetchValid_i;
  logic [31:0] FetchData_i;
  logic        Redirect_i;
  logic [31:0] RedirectPC_i;
  logic        InstrValid_o;
  logic        InstrReady_i;
  logic [31:0] Instr_o;
  logic [31:0] InstrPC_o;
  logic        Compressed_o;
  logic        Illegal_o;

  instr_align_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .FetchAddr_o(FetchAddr_o), .FetchReady_o(FetchReady_o),
    .FetchValid_i(FetchValid_i), .FetchData_i(FetchData_i),
    .Redirect_i(Redirect_i), .RedirectPC_i(RedirectPC_i),
    .InstrValid_o(InstrValid_o), .InstrReady_i(InstrReady_i),
    .Instr_o(Instr_o), .InstrPC_o(InstrPC_o),
    .Compressed_o(Compressed_o), .Illegal_o(Illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Word stored at address a: addi x0,x0,a[11:0] -- a 32-bit encoding unique per address.
  function automatic logic [31:0] wrd(input logic [31:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] fa;
    logic        frdy;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        cmp;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [31:0] fd, input logic ir,
                              input logic rd, input logic [31:0] rpc, input logic [31:0] fa,
                              input logic frdy, input logic iv, input logic [31:0] instr,
                              input logic [31:0] pc, input logic cmp);
    vec_t v;
    v.fv = fv; v.fd = fd; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.fa = fa; v.frdy = frdy; v.iv = iv; v.instr = instr; v.pc = pc; v.cmp = cmp;
    return v;
  endfunction

  vec_t        tbl [15];
  logic [31:0] c1, c2, cnop;
  logic [31:0] exp_pc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef RVC_EXPAND_EN
    c1 = 32'h0015_0513; c2 = 32'h0010_0593; cnop = 32'h0000_0013;
`else
    c1 = 32'h0000_0505; c2 = 32'h0000_4585; cnop = 32'h0000_0001;
`endif
    //           fv  fd            ir rd rpc          fa            frdy iv instr          pc            cmp
    tbl[0]  = mk(1, 32'h00A00093, 1, 0, 32'h0,     32'h0,        1, 0, 32'h0,         32'h0,        0);
    tbl[1]  = mk(1, 32'h00B00113, 1, 0, 32'h0,     32'h4,        1, 1, 32'h00A00093,  32'h0,        0);
    tbl[2]  = mk(1, 32'h45850505, 1, 0, 32'h0,     32'h8,        1, 1, 32'h00B00113,  32'h4,        0);
    tbl[3]  = mk(0, 32'h0,        1, 0, 32'h0,     32'hC,        1, 1, c1,            32'h8,        1);
    tbl[4]  = mk(0, 32'h0,        1, 0, 32'h0,     32'hC,        1, 1, c2,            32'hA,        1);
    tbl[5]  = mk(1, 32'h01930001, 1, 0, 32'h0,     32'hC,        1, 0, 32'h0,         32'hC,        0);
    tbl[6]  = mk(0, 32'h0,        1, 0, 32'h0,     32'h10,       1, 1, cnop,          32'hC,        1);
    tbl[7]  = mk(0, 32'h0,        1, 0, 32'h0,     32'h10,       1, 0, 32'h0,         32'hE,        0);
    tbl[8]  = mk(1, 32'h000100C0, 1, 0, 32'h0,     32'h10,       1, 0, 32'h0,         32'hE,        0);
    tbl[9]  = mk(0, 32'h0,        1, 0, 32'h0,     32'h14,       0, 1, 32'h00C00193,  32'hE,        0);
    tbl[10] = mk(0, 32'h0,        0, 0, 32'h0,     32'h14,       1, 1, cnop,          32'h12,       1);
    tbl[11] = mk(1, 32'hDEADBEEF, 1, 1, 32'h102,   32'h14,       0, 0, 32'h0,         32'h12,       0);
    tbl[12] = mk(1, 32'h4585FFFF, 1, 0, 32'h0,     32'h100,      1, 0, 32'h0,         32'h102,      0);
    tbl[13] = mk(0, 32'h0,        1, 0, 32'h0,     32'h104,      1, 1, c2,            32'h102,      1);
    tbl[14] = mk(0, 32'h0,        1, 0, 32'h0,     32'h104,      1, 0, 32'h0,         32'h104,      0);

    rst_i = 1'b1; FetchValid_i = 0; FetchData_i = '0; Redirect_i = 0; RedirectPC_i = '0;
    InstrReady_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #2;
    chk("rst_fa",    FetchAddr_o,  32'h0);
    chk("rst_frdy",  32'(FetchReady_o), 32'h1);
    chk("rst_iv",    32'(InstrValid_o), 32'h0);
    chk("rst_instr", Instr_o,      32'h0);
    chk("rst_pc",    InstrPC_o,    32'h0);
    chk("rst_cmp",   32'(Compressed_o), 32'h0);
    chk("rst_ill",   32'(Illegal_o), 32'h0);
    #1;

    // Table: basic stream, compressed pair, straddling 32-bit instr, stall, redirect with drop.
    for (int i = 0; i < 15; i++) begin
      FetchValid_i = tbl[i].fv; FetchData_i = tbl[i].fd; InstrReady_i = tbl[i].ir;
      Redirect_i   = tbl[i].rd; RedirectPC_i = tbl[i].rpc;
      #2;
      chk($sformatf("v%0d_fa", i),    FetchAddr_o,            tbl[i].fa);
      chk($sformatf("v%0d_frdy", i),  32'(FetchReady_o),      32'(tbl[i].frdy));
      chk($sformatf("v%0d_iv", i),    32'(InstrValid_o),      32'(tbl[i].iv));
      chk($sformatf("v%0d_instr", i), Instr_o,                tbl[i].instr);
      chk($sformatf("v%0d_pc", i),    InstrPC_o,              tbl[i].pc);
      chk($sformatf("v%0d_cmp", i),   32'(Compressed_o),      32'(tbl[i].cmp));
      chk($sformatf("v%0d_ill", i),   32'(Illegal_o),         32'h0);
      @(posedge clk_i); #1;
    end

    // Redirect to 0x200, then hold decode off for 8 cycles while fetch keeps offering words.
    Redirect_i = 1; RedirectPC_i = 32'h200; FetchValid_i = 0; InstrReady_i = 0;
    @(posedge clk_i); #1;
    Redirect_i = 0;
    for (int s = 0; s < 8; s++) begin
      FetchValid_i = 1; FetchData_i = wrd(FetchAddr_o); InstrReady_i = 0;
      #2;
      chk($sformatf("stall%0d_fa", s),   FetchAddr_o,
          (s == 0) ? 32'h200 : (s == 1) ? 32'h204 : 32'h208);
      chk($sformatf("stall%0d_frdy", s), 32'(FetchReady_o), (s < 2) ? 32'h1 : 32'h0);
      chk($sformatf("stall%0d_iv", s),   32'(InstrValid_o), (s == 0) ? 32'h0 : 32'h1);
      if (s > 0) begin
        chk($sformatf("stall%0d_instr", s), Instr_o,   wrd(32'h200));
        chk($sformatf("stall%0d_pc", s),    InstrPC_o, 32'h200);
      end
      @(posedge clk_i); #1;
    end

    // Release: every instruction must come out in order with no gaps.
    exp_pc = 32'h200;
    for (int r = 0; r < 14; r++) begin
      FetchValid_i = 1; FetchData_i = wrd(FetchAddr_o); InstrReady_i = 1;
      #2;
      if (InstrValid_o) begin
        chk($sformatf("drain%0d_instr", r), Instr_o,   wrd(exp_pc));
        chk($sformatf("drain%0d_pc", r),    InstrPC_o, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk_i); #1;
    end
    chk("drain_progress", 32'(exp_pc >= 32'h230), 32'h1);

    // Fill the buffer, then pulse reset in the middle of a cycle.
    for (int f = 0; f < 4; f++) begin
      FetchValid_i = 1; FetchData_i = wrd(FetchAddr_o); InstrReady_i = 0;
      #2;
      if (f == 3) begin
        chk("full_frdy", 32'(FetchReady_o), 32'h0);
        chk("full_iv",   32'(InstrValid_o), 32'h1);
      end
      @(posedge clk_i); #1;
    end
    FetchValid_i = 1; InstrReady_i = 1;
    #1 rst_i = 1'b1;
    #1;
    chk("arst_fa",    FetchAddr_o,            32'h0);
    chk("arst_frdy",  32'(FetchReady_o),      32'h1);
    chk("arst_iv",    32'(InstrValid_o),      32'h0);
    chk("arst_instr", Instr_o,                32'h0);
    chk("arst_pc",    InstrPC_o,              32'h0);
    chk("arst_cmp",   32'(Compressed_o),      32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    FetchValid_i = 1; FetchData_i = 32'h00A00093; InstrReady_i = 1;
    #2;
    chk("post_rst_fa", FetchAddr_o,       32'h0);
    chk("post_rst_iv", 32'(InstrValid_o), 32'h0);
    @(posedge clk_i); #1;
    FetchValid_i = 0;
    #2;
    chk("post_rst_iv1",    32'(InstrValid_o), 32'h1);
    chk("post_rst_instr",  Instr_o,           32'h00A00093);
    chk("post_rst_pc",     InstrPC_o,         32'h0);
    @(posedge clk_i); #1;

    // Upper-halfword redirect at the top of the address space: fetch address and PC wrap.
    Redirect_i = 1; RedirectPC_i = 32'hFFFF_FFFE; InstrReady_i = 0;
    @(posedge clk_i); #1;
    Redirect_i = 0; FetchValid_i = 1; FetchData_i = 32'h4585FFFF;
    #2;
    chk("wrap_fa0", FetchAddr_o, 32'hFFFF_FFFC);
    chk("wrap_pc0", InstrPC_o,   32'hFFFF_FFFE);
    @(posedge clk_i); #1;
    FetchValid_i = 0; InstrReady_i = 1;
    #2;
    chk("wrap_fa1",    FetchAddr_o,       32'h0);
    chk("wrap_iv",     32'(InstrValid_o), 32'h1);
    chk("wrap_instr",  Instr_o,           c2);
    chk("wrap_cmp",    32'(Compressed_o), 32'h1);
    @(posedge clk_i); #1;
    InstrReady_i = 0;
    #2;
    chk("wrap_pc1",    InstrPC_o,         32'h0);
    chk("wrap_iv_end", 32'(InstrValid_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
